seq_event_arbiter: RTL and testbench
====================================

SEQ_EVENT_ARBITER -- requirements
Module: seq_event_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of each per-channel accepted-event counter.
REQ-002 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 hit  input  3  SHALL carry per-channel detection pulses, bit0=W, bit1=X, bit2=Y; each high cycle is one event.
REQ-005 enable  input  1  SHALL gate event capture; 0 = ignore hit.
REQ-006 evt_valid  output  1  SHALL indicate an event is offered to the consumer.
REQ-007 evt_ready  input  1  SHALL indicate the consumer accepts; handshake = evt_valid & evt_ready at a rising edge.
REQ-008 evt_id  output  2  SHALL identify the offered channel (0=W, 1=X, 2=Y); 3 is never driven.
REQ-009 evt_overrun  output  1  SHALL be the OR of the three sticky per-channel overrun flags.
REQ-010 ovr_clr  input  1  SHALL clear all overrun flags.
REQ-011 cnt_sel  input  2  SHALL select the counter shown on cnt_value (3 reads as 0).
REQ-012 cnt_value  output  CNT_W  SHALL show the selected counter combinationally.
REQ-013 cnt_clr  input  1  SHALL clear all counters.

Function
REQ-014 Per-channel pending bit SHALL be set at the edge where hit[i]=1 and enable=1.
REQ-015 Pending[i] SHALL clear on handshake with evt_id=i, unless hit[i]=1 in the same cycle; then it stays set and no overrun occurs.
REQ-016 hit[i]=1 while pending[i]=1 and not cleared that cycle SHALL set overrun[i]; the event is dropped.
REQ-017 ovr_clr coinciding with a new overrun SHALL leave the flag set (set wins).
REQ-018 FSM states IDLE and OFFER; reset state IDLE.
REQ-019 IDLE: if any pending, select a channel and move to OFFER, evt_valid=1 from the next cycle; otherwise remain in IDLE.
REQ-020 Selection SHALL be round-robin: search order ptr, ptr+1, ptr+2 (mod 3); first pending wins.
REQ-021 OFFER: evt_valid and evt_id SHALL hold stable until handshake; evt_valid SHALL never drop without handshake.
REQ-022 On handshake, ptr SHALL become (evt_id+1) mod 3 and FSM SHALL return to IDLE; max throughput is one event per 2 cycles.
REQ-023 Latency: hit sampled at edge N; evt_valid high after edge N+1 if FSM was IDLE with no other pending.
REQ-024 enable=0 SHALL not abort OFFER or clear existing pending bits; only new capture stops.
REQ-025 Counter[i] SHALL increment on handshake with evt_id=i and saturate at 2^CNT_W-1.
REQ-026 cnt_clr coinciding with increment SHALL yield 0 (clear wins).

Reset
REQ-027 Reset SHALL force: FSM=IDLE, pending=0, ptr=0, overrun flags=0, counters=0, evt_valid=0, evt_id=0.
REQ-028 Reset asserted mid-OFFER SHALL drop the offered event with no handshake counted.

Configuration
REQ-029 Macro SEQ_EVENT_ARBITER_CNT_EN defined: counters, cnt_sel, cnt_clr, cnt_value present per REQ-011..013, REQ-025, REQ-026.
REQ-030 Macro undefined: no counter flops; ports remain; cnt_value SHALL read constant 0; cnt_sel and cnt_clr ignored.

Structure
REQ-031 Package seq_event_pkg SHALL hold channel constants CH_W=0, CH_X=1, CH_Y=2, NUM_CH=3, and the FSM state type.
REQ-032 Sub-module rr_arb3 (combinational: pending[2:0], ptr -> grant id, any) SHALL implement REQ-020.

Verification
REQ-033 Single hit: reset, hit=001 one cycle, evt_ready=1 -> evt_valid high after edge N+1, evt_id=0, counter W=1.
REQ-034 Fairness: hit=111 once, evt_ready=1 -> evt_id sequence 0,1,2; next hit=111 -> 0,1,2 again (ptr back at 0).
REQ-035 Backpressure: hit=010, evt_ready=0 for 5 cycles -> evt_valid, evt_id=1 stable; second hit[1] -> evt_overrun=1; ovr_clr -> 0.
REQ-036 Simultaneous: handshake on X with hit[1]=1 same cycle -> no overrun, X offered again after IDLE.
REQ-037 Saturation (CNT_W=2): 5 accepted W events -> cnt_value=3 at cnt_sel=0; cnt_clr -> 0; macro undefined -> always 0.
REQ-038 Mid-offer reset: OFFER on Y, reset pulse -> evt_valid=0, pending=0, counters=0, next hit=001 yields evt_id=0.

Source files
------------

// File: rtl/seq_event_pkg.sv
// Shared constants and types for the event arbiter.
// Channel ids, FSM state type and a mod-3 increment helper.
package seq_event_pkg;

  localparam logic [1:0] CH_W = 2'd0;
  localparam logic [1:0] CH_X = 2'd1;
  localparam logic [1:0] CH_Y = 2'd2;
  localparam int NUM_CH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [1:0] ch_inc(input logic [1:0] c);
    return (c == CH_Y) ? CH_W : c + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker, purely combinational.
// Searches ptr, ptr+1, ptr+2 (mod 3); first pending wins.
module rr_arb3
  import seq_event_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // Rotated search order starting at the pointer
  always_comb begin
    c0     = (ptr == 2'd3) ? CH_W : ptr;
    c1     = ch_inc(c0);
    c2     = ch_inc(c1);
    any    = |pending;
    gnt_id = CH_W;
    if (pending[c0])      gnt_id = c0;
    else if (pending[c1]) gnt_id = c1;
    else if (pending[c2]) gnt_id = c2;
  end

endmodule

// File: rtl/seq_event_arbiter.sv
// Captures per-channel hit pulses and offers them round-robin on a
// valid/ready port. Counters built only with SEQ_EVENT_ARBITER_CNT_EN.
module seq_event_arbiter
  import seq_event_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       hit,
  input  logic             enable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_id,
  output logic             evt_overrun,
  input  logic             ovr_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_clr
);

  state_e     state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] ovr_q, ovr_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] id_q, id_d;
  logic [2:0] hs_ch;
  logic [2:0] cap;
  logic [2:0] new_ovr;
  logic [1:0] gnt_id;
  logic       any;
  logic       hs;

  rr_arb3 u_arb (
    .pending (pend_q),
    .ptr     (ptr_q),
    .gnt_id  (gnt_id),
    .any     (any)
  );

  // FSM output: valid is high for the whole OFFER state
  always_comb begin
    evt_valid = (state_q == OFFER);
    evt_id    = id_q;
  end

  assign hs          = evt_valid & evt_ready;
  assign evt_overrun = |ovr_q;

  // Pending capture, handshake clear and overrun detection
  always_comb begin
    pend_d  = pend_q;
    new_ovr = '0;
    cap     = hit & {3{enable}};
    hs_ch   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hs_ch[i] = hs && (id_q == 2'(i));
      if (hs_ch[i])      pend_d[i] = cap[i];
      else if (cap[i]) begin
        pend_d[i]  = 1'b1;
        new_ovr[i] = pend_q[i];
      end
    end
    ovr_d = (ovr_q & ~{3{ovr_clr}}) | new_ovr;
  end

  // FSM next state, offered id and round-robin pointer
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = OFFER;
          id_d    = gnt_id;
        end
      end
      OFFER: begin
        if (hs) begin
          state_d = IDLE;
          ptr_d   = ch_inc(id_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovr_q   <= '0;
      ptr_q   <= CH_W;
      id_q    <= CH_W;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

`ifdef SEQ_EVENT_ARBITER_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Saturating accept counters; clear beats increment
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr)
        cnt_d[i] = '0;
      else if (hs_ch[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Counter readback mux; select 3 reads zero
  always_comb begin
    unique case (cnt_sel)
      2'd0:    cnt_value = cnt_q[0];
      2'd1:    cnt_value = cnt_q[1];
      2'd2:    cnt_value = cnt_q[2];
      default: cnt_value = '0;
    endcase
  end
`else
  logic unused_cnt;

  assign unused_cnt = ^{cnt_sel, cnt_clr, hs_ch};

  // Counters absent: readback is constant zero
  always_comb begin
    cnt_value = '0;
  end
`endif

endmodule

// File: tb/tb_seq_event_arbiter.sv
// Directed self-checking bench for seq_event_arbiter.
// Counter expectations follow SEQ_EVENT_ARBITER_CNT_EN.
module tb_seq_event_arbiter;

  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic [2:0]    hit;
  logic          enable;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_id;
  logic          evt_overrun;
  logic          ovr_clr;
  logic [1:0]    cnt_sel;
  logic [CW-1:0] cnt_value;
  logic          cnt_clr;

  int n_chk;
  int n_err;

  seq_event_arbiter #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .hit         (hit),
    .enable      (enable),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_overrun (evt_overrun),
    .ovr_clr     (ovr_clr),
    .cnt_sel     (cnt_sel),
    .cnt_value   (cnt_value),
    .cnt_clr     (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ce(input int v);
`ifdef SEQ_EVENT_ARBITER_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] h);
    hit = h;
    tick();
    hit = 3'b000;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    hit       = '0;
    enable    = 1'b1;
    evt_ready = 1'b0;
    ovr_clr   = 1'b0;
    cnt_sel   = 2'd0;
    cnt_clr   = 1'b0;
    do_reset();
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_ovr", int'(evt_overrun), 0);
    chk("rst_cnt", int'(cnt_value), 0);

    // single hit latency
    evt_ready = 1'b1;
    pulse(3'b001);
    chk("single_n", int'(evt_valid), 0);
    tick();
    chk("single_n1_v", int'(evt_valid), 1);
    chk("single_n1_id", int'(evt_id), 0);
    tick();
    chk("single_done", int'(evt_valid), 0);
    chk("single_cnt", int'(cnt_value), ce(1));

    // fairness, two rounds from ptr=0
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pulse(3'b111);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("rr_valid", int'(evt_valid), 1);
        chk("rr_id", int'(evt_id), k);
        tick();
        chk("rr_gap", int'(evt_valid), 0);
      end
    end
    cnt_sel = 2'd1;
    chk("rr_cnt_x", int'(cnt_value), ce(2));
    cnt_sel = 2'd3;
    chk("rr_cnt_sel3", int'(cnt_value), 0);
    cnt_sel = 2'd0;

    // backpressure and overrun
    evt_ready = 1'b0;
    pulse(3'b010);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", int'({evt_valid, evt_id}), 5);
    end
    pulse(3'b010);
    chk("bp_ovr", int'(evt_overrun), 1);
    chk("bp_still", int'({evt_valid, evt_id}), 5);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", int'(evt_overrun), 0);
    evt_ready = 1'b1;
    tick();
    chk("bp_accept", int'(evt_valid), 0);

    // handshake and hit on same channel
    evt_ready = 1'b0;
    pulse(3'b010);
    tick();
    chk("sim_offer", int'({evt_valid, evt_id}), 5);
    evt_ready = 1'b1;
    pulse(3'b010);
    chk("sim_no_ovr", int'(evt_overrun), 0);
    chk("sim_idle", int'(evt_valid), 0);
    tick();
    chk("sim_reoffer", int'({evt_valid, evt_id}), 5);
    tick();
    chk("sim_drain", int'(evt_valid), 0);

    // overrun set beats clear
    evt_ready = 1'b0;
    pulse(3'b100);
    tick();
    chk("sw_offer", int'({evt_valid, evt_id}), 6);
    ovr_clr = 1'b1;
    pulse(3'b100);
    ovr_clr = 1'b0;
    chk("sw_set_wins", int'(evt_overrun), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("sw_cleared", int'(evt_overrun), 0);
    evt_ready = 1'b1;
    tick();

    // enable low ignores hits
    enable = 1'b0;
    pulse(3'b111);
    tick();
    chk("en_off", int'(evt_valid), 0);
    enable = 1'b1;

    // saturation at CNT_W=2
    do_reset();
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pulse(3'b001);
      tick();
      tick();
    end
    cnt_sel = 2'd0;
    chk("sat_w", int'(cnt_value), ce(3));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", int'(cnt_value), 0);
    pulse(3'b001);
    tick();
    chk("cw_offer", int'(evt_valid), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", int'(cnt_value), 0);

    // reset in the middle of an offer
    pulse(3'b001);
    tick();
    tick();
    chk("mr_pre_cnt", int'(cnt_value), ce(1));
    evt_ready = 1'b0;
    pulse(3'b100);
    tick();
    chk("mr_offer", int'({evt_valid, evt_id}), 6);
    pulse(3'b001);
    reset = 1'b1;
    #2;
    chk("mr_async_v", int'(evt_valid), 0);
    chk("mr_async_id", int'(evt_id), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("mr_no_pend", int'(evt_valid), 0);
    chk("mr_cnt", int'(cnt_value), 0);
    evt_ready = 1'b1;
    pulse(3'b101);
    tick();
    chk("mr_next", int'({evt_valid, evt_id}), 4);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
